// File: rtl/motor_cmd_sequencer.sv
// Run/stop/clear command sequencer in front of the BLE motor driver stage.
// Arbitrates host and panel commands, enforces reversal dwell and alarm recovery.
module motor_cmd_sequencer #(
    parameter logic [31:0] DWELL_CYC     = 32'd10_000_000,
    parameter logic [31:0] PULSE_CYC     = 32'd1_000_000,
    parameter logic [31:0] ALARM_DEB_CYC = 32'd1_000,
    parameter logic [1:0]  MAX_RETRY     = 2'd3
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       host_req_valid,
    input  logic [1:0] host_req_cmd,
    output logic       host_req_ready,
    input  logic       panel_req_valid,
    input  logic [1:0] panel_req_cmd,
    output logic       panel_req_ready,
    input  logic       alarm_out_n,
    output logic       motor_state,
    output logic       motor_direction,
    output logic       motor_alarm_reset,
    output logic       fault,
    output logic [1:0] retry_cnt,
    output logic [2:0] seq_state
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RUN     = 3'd1,
        S_BRAKE   = 3'd2,
        S_ALARM   = 3'd3,
        S_CLEAR   = 3'd4,
        S_LOCKOUT = 3'd5
    } state_t;

    typedef enum logic [1:0] {
        CMD_STOP  = 2'b00,
        CMD_FWD   = 2'b01,
        CMD_REV   = 2'b10,
        CMD_CLEAR = 2'b11
    } cmd_t;

    state_t      state;
    logic [31:0] timer;
    logic [31:0] deb_cnt;
    logic [1:0]  alarm_sync;
    logic        clear_wait;
    logic        pend_valid;
    logic        pend_dir;
    logic        alarm_hit;
    logic        host_ok;
    logic        panel_ok;
    logic        acc_valid;
    logic [1:0]  acc_cmd;
    logic [1:0]  retry_next;

    function automatic logic cmd_ok(input state_t s, input logic [1:0] c, input logic from_panel);
        case (s)
            S_IDLE, S_RUN: cmd_ok = 1'b1;
            S_BRAKE:       cmd_ok = (c == CMD_STOP);
            S_ALARM:       cmd_ok = (c == CMD_CLEAR) || (c == CMD_STOP);
            S_LOCKOUT:     cmd_ok = from_panel && (c == CMD_CLEAR);
            default:       cmd_ok = 1'b0;
        endcase
    endfunction

    assign seq_state  = state;
    assign retry_next = retry_cnt + 2'd1;
    assign alarm_hit  = (deb_cnt >= ALARM_DEB_CYC) && (state inside {S_IDLE, S_RUN, S_BRAKE});

    // Readiness is withheld while an alarm is being declared so no command is silently dropped.
    always_comb begin
        host_ok         = host_req_valid && cmd_ok(state, host_req_cmd, 1'b0) && !alarm_hit;
        panel_ok        = panel_req_valid && cmd_ok(state, panel_req_cmd, 1'b1) && !alarm_hit;
        host_req_ready  = 1'b0;
        panel_req_ready = 1'b0;
        if (panel_ok && panel_req_cmd == CMD_STOP)
            panel_req_ready = 1'b1;
        else if (host_ok && host_req_cmd == CMD_STOP)
            host_req_ready = 1'b1;
        else if (panel_ok)
            panel_req_ready = 1'b1;
        else if (host_ok)
            host_req_ready = 1'b1;
        acc_valid = host_req_ready || panel_req_ready;
        acc_cmd   = panel_req_ready ? panel_req_cmd : host_req_cmd;
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state             <= S_IDLE;
            timer             <= '0;
            deb_cnt           <= '0;
            alarm_sync        <= '1;
            clear_wait        <= 1'b0;
            pend_valid        <= 1'b0;
            pend_dir          <= 1'b0;
            motor_state       <= 1'b0;
            motor_direction   <= 1'b0;
            motor_alarm_reset <= 1'b0;
            fault             <= 1'b0;
            retry_cnt         <= '0;
        end else begin
            alarm_sync <= {alarm_sync[0], alarm_out_n};
            if (alarm_sync[1])
                deb_cnt <= '0;
            else if (deb_cnt != '1)
                deb_cnt <= deb_cnt + 32'd1;
            if (timer != '1)
                timer <= timer + 32'd1;

            if (alarm_hit) begin
                state       <= S_ALARM;
                timer       <= '0;
                motor_state <= 1'b0;
                pend_valid  <= 1'b0;
                fault       <= 1'b1;
            end else begin
                case (state)
                    S_IDLE: begin
                        if (acc_valid && (acc_cmd == CMD_FWD || acc_cmd == CMD_REV)) begin
                            state           <= S_RUN;
                            timer           <= '0;
                            motor_state     <= 1'b1;
                            motor_direction <= (acc_cmd == CMD_FWD);
                            pend_valid      <= 1'b0;
                        end
                    end
                    S_RUN: begin
                        if (acc_valid && acc_cmd == CMD_STOP) begin
                            state       <= S_BRAKE;
                            timer       <= '0;
                            motor_state <= 1'b0;
                            pend_valid  <= 1'b0;
                        end else if (acc_valid && (acc_cmd == CMD_FWD || acc_cmd == CMD_REV)
                                     && ((acc_cmd == CMD_FWD) != motor_direction)) begin
                            state       <= S_BRAKE;
                            timer       <= '0;
                            motor_state <= 1'b0;
                            pend_valid  <= 1'b1;
                            pend_dir    <= (acc_cmd == CMD_FWD);
                        end
                    end
                    S_BRAKE: begin
                        if (acc_valid)
                            pend_valid <= 1'b0;
                        if (timer >= DWELL_CYC - 32'd1) begin
                            timer <= '0;
                            // A STOP landing on the final dwell cycle still cancels the restart.
                            if (pend_valid && !acc_valid) begin
                                state           <= S_RUN;
                                motor_state     <= 1'b1;
                                motor_direction <= pend_dir;
                                pend_valid      <= 1'b0;
                            end else begin
                                state <= S_IDLE;
                            end
                        end
                    end
                    S_ALARM: begin
                        if (acc_valid && acc_cmd == CMD_CLEAR) begin
                            state             <= S_CLEAR;
                            timer             <= '0;
                            clear_wait        <= 1'b0;
                            motor_alarm_reset <= 1'b1;
                        end
                    end
                    S_CLEAR: begin
                        if (!clear_wait) begin
                            if (timer >= PULSE_CYC - 32'd1) begin
                                timer             <= '0;
                                clear_wait        <= 1'b1;
                                motor_alarm_reset <= 1'b0;
                            end
                        end else if (timer >= DWELL_CYC - 32'd1) begin
                            timer      <= '0;
                            clear_wait <= 1'b0;
                            if (alarm_sync[1]) begin
                                state     <= S_IDLE;
                                retry_cnt <= '0;
                                fault     <= 1'b0;
                            end else begin
                                retry_cnt <= retry_next;
                                if (retry_next == MAX_RETRY) begin
                                    state           <= S_LOCKOUT;
                                    motor_direction <= 1'b0;
                                end else begin
                                    state <= S_ALARM;
                                end
                            end
                        end
                    end
                    S_LOCKOUT: begin
                        if (acc_valid && alarm_sync[1]) begin
                            state     <= S_IDLE;
                            timer     <= '0;
                            retry_cnt <= '0;
                            fault     <= 1'b0;
                        end
                    end
                    default: begin
                        state <= S_IDLE;
                        timer <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_motor_cmd_sequencer.sv
// Bench for motor_cmd_sequencer: directed scenarios plus random traffic,
// compared every cycle against a countdown-based behavioural model.
module tb_motor_cmd_sequencer;

    localparam int DWELL = 20;
    localparam int PULSE = 8;
    localparam int DEB   = 10;
    localparam int MAXR  = 3;

    logic       sys_clk;
    logic       sys_rst_n;
    logic       host_req_valid;
    logic [1:0] host_req_cmd;
    logic       host_req_ready;
    logic       panel_req_valid;
    logic [1:0] panel_req_cmd;
    logic       panel_req_ready;
    logic       alarm_out_n;
    logic       motor_state;
    logic       motor_direction;
    logic       motor_alarm_reset;
    logic       fault;
    logic [1:0] retry_cnt;
    logic [2:0] seq_state;

    motor_cmd_sequencer #(
        .DWELL_CYC    (32'(DWELL)),
        .PULSE_CYC    (32'(PULSE)),
        .ALARM_DEB_CYC(32'(DEB)),
        .MAX_RETRY    (2'(MAXR))
    ) dut (
        .sys_clk          (sys_clk),
        .sys_rst_n        (sys_rst_n),
        .host_req_valid   (host_req_valid),
        .host_req_cmd     (host_req_cmd),
        .host_req_ready   (host_req_ready),
        .panel_req_valid  (panel_req_valid),
        .panel_req_cmd    (panel_req_cmd),
        .panel_req_ready  (panel_req_ready),
        .alarm_out_n      (alarm_out_n),
        .motor_state      (motor_state),
        .motor_direction  (motor_direction),
        .motor_alarm_reset(motor_alarm_reset),
        .fault            (fault),
        .retry_cnt        (retry_cnt),
        .seq_state        (seq_state)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Model: mode numbers follow the published seq_state encoding; timers count down.
    int m_mode, m_left, m_pend, m_retry, m_low;
    bit m_phase, m_run, m_dir, m_rst, m_s1, m_s2;
    bit rdy_h, rdy_p;

    task automatic model_reset();
        m_mode = 0; m_left = 0; m_pend = -1; m_retry = 0; m_low = 0;
        m_phase = 0; m_run = 0; m_dir = 0; m_rst = 0; m_s1 = 1; m_s2 = 1;
    endtask

    function automatic bit allowed(input int mode, input logic [1:0] c, input bit panel);
        case (mode)
            0, 1:    return 1'b1;
            2:       return c == 2'd0;
            3:       return c == 2'd3 || c == 2'd0;
            5:       return panel && c == 2'd3;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_ready(output bit rh, output bit rp);
        bit hit, ch, cp;
        hit = (m_low >= DEB) && (m_mode <= 2);
        ch = host_req_valid && allowed(m_mode, host_req_cmd, 1'b0) && !hit;
        cp = panel_req_valid && allowed(m_mode, panel_req_cmd, 1'b1) && !hit;
        rh = 0; rp = 0;
        if (cp && panel_req_cmd == 2'd0)     rp = 1;
        else if (ch && host_req_cmd == 2'd0) rh = 1;
        else if (cp)                         rp = 1;
        else if (ch)                         rh = 1;
    endtask

    task automatic model_step();
        bit rh, rp, acc, hit, s2_pre;
        logic [1:0] c;
        model_ready(rh, rp);
        acc = rh || rp;
        c = rp ? panel_req_cmd : host_req_cmd;
        s2_pre = m_s2;
        hit = (m_low >= DEB) && (m_mode <= 2);
        if (hit) begin
            m_mode = 3; m_run = 0; m_pend = -1;
        end else begin
            case (m_mode)
                0: if (acc && (c == 2'd1 || c == 2'd2)) begin
                       m_mode = 1; m_run = 1; m_dir = (c == 2'd1);
                   end
                1: if (acc) begin
                       if (c == 2'd0) begin
                           m_pend = -1; m_run = 0; m_mode = 2; m_left = DWELL;
                       end else if ((c == 2'd1 || c == 2'd2) && ((c == 2'd1) != m_dir)) begin
                           m_pend = (c == 2'd1) ? 1 : 0; m_run = 0; m_mode = 2; m_left = DWELL;
                       end
                   end
                2: begin
                       if (acc) m_pend = -1;
                       if (m_left <= 1) begin
                           if (m_pend >= 0) begin
                               m_mode = 1; m_run = 1; m_dir = (m_pend == 1); m_pend = -1;
                           end else m_mode = 0;
                       end else m_left--;
                   end
                3: if (acc && c == 2'd3) begin
                       m_mode = 4; m_rst = 1; m_phase = 0; m_left = PULSE;
                   end
                4: if (m_left <= 1) begin
                       if (!m_phase) begin
                           m_rst = 0; m_phase = 1; m_left = DWELL;
                       end else if (s2_pre) begin
                           m_mode = 0; m_retry = 0;
                       end else begin
                           m_retry++;
                           if (m_retry == MAXR) begin m_mode = 5; m_dir = 0; end
                           else m_mode = 3;
                       end
                   end else m_left--;
                5: if (acc && s2_pre) begin m_mode = 0; m_retry = 0; end
                default: ;
            endcase
        end
        m_low = s2_pre ? 0 : m_low + 1;
        m_s2 = m_s1;
        m_s1 = alarm_out_n;
    endtask

    // One clock cycle: inputs set by the caller just after a falling edge.
    task automatic cyc();
        bit eh, ep;
        #1;
        rdy_h = host_req_ready;
        rdy_p = panel_req_ready;
        if (sys_rst_n) begin
            model_ready(eh, ep);
            check_eq("host_ready", 32'(host_req_ready), 32'(eh));
            check_eq("panel_ready", 32'(panel_req_ready), 32'(ep));
        end
        @(posedge sys_clk);
        if (sys_rst_n) model_step(); else model_reset();
        #1;
        check_eq("motor_state", 32'(motor_state), 32'(m_run));
        check_eq("motor_direction", 32'(motor_direction), 32'(m_dir));
        check_eq("motor_alarm_reset", 32'(motor_alarm_reset), 32'(m_rst));
        check_eq("fault", 32'(fault), 32'(m_mode >= 3));
        check_eq("retry_cnt", 32'(retry_cnt), 32'(m_retry));
        check_eq("seq_state", 32'(seq_state), 32'(m_mode));
        @(negedge sys_clk);
    endtask

    task automatic idle_inputs();
        host_req_valid = 0; panel_req_valid = 0;
    endtask

    task automatic host_cmd(input logic [1:0] c);
        host_req_valid = 1; host_req_cmd = c; cyc(); host_req_valid = 0;
    endtask

    task automatic panel_cmd(input logic [1:0] c);
        panel_req_valid = 1; panel_req_cmd = c; cyc(); panel_req_valid = 0;
    endtask

    task automatic leave_state(input logic [2:0] s, input string tag);
        int guard = 0;
        while (seq_state == s && guard < 400) begin cyc(); guard++; end
        check_eq(tag, 32'(seq_state != s), 32'd1);
    endtask

    task automatic reach_state(input logic [2:0] s, input string tag);
        int guard = 0;
        while (seq_state != s && guard < 400) begin cyc(); guard++; end
        check_eq(tag, 32'(seq_state), 32'(s));
    endtask

    initial begin
        int cnt, burst;
        sys_rst_n = 0; alarm_out_n = 1;
        host_req_valid = 0; host_req_cmd = 0; panel_req_valid = 0; panel_req_cmd = 0;
        model_reset();
        repeat (3) @(negedge sys_clk);
        check_eq("rst_motor_state", 32'(motor_state), 32'd0);
        check_eq("rst_alarm_reset", 32'(motor_alarm_reset), 32'd0);
        check_eq("rst_fault", 32'(fault), 32'd0);
        check_eq("rst_seq_state", 32'(seq_state), 32'd0);
        sys_rst_n = 1;
        repeat (3) cyc();

        // 1: host FWD from IDLE
        host_cmd(2'b01);
        check_eq("t1_ready", 32'(rdy_h), 32'd1);
        check_eq("t1_run", 32'(motor_state), 32'd1);
        check_eq("t1_dir", 32'(motor_direction), 32'd1);
        check_eq("t1_state", 32'(seq_state), 32'd1);

        // 2: panel REV reversal with dwell; host FWD back-pressured in BRAKE
        panel_cmd(2'b10);
        cnt = 0;
        host_req_valid = 1; host_req_cmd = 2'b01;
        cnt++; cyc(); host_req_valid = 0;
        check_eq("t2_brake_host_ready", 32'(rdy_h), 32'd0);
        while (motor_state == 0 && cnt < 200) begin cnt++; cyc(); end
        check_eq("t2_dwell_len", 32'(cnt), 32'(DWELL));
        check_eq("t2_run", 32'(motor_state), 32'd1);
        check_eq("t2_dir", 32'(motor_direction), 32'd0);

        // 3: host STOP beats panel FWD
        host_req_valid = 1; host_req_cmd = 2'b00;
        panel_req_valid = 1; panel_req_cmd = 2'b01;
        cyc(); idle_inputs();
        check_eq("t3_host_ready", 32'(rdy_h), 32'd1);
        check_eq("t3_panel_ready", 32'(rdy_p), 32'd0);
        check_eq("t3_brake", 32'(seq_state), 32'd2);
        repeat (DWELL + 2) cyc();
        check_eq("t3_idle", 32'(seq_state), 32'd0);

        // 4: debounce boundary, then successful clear
        host_cmd(2'b01);
        alarm_out_n = 0; repeat (DEB - 1) cyc();
        alarm_out_n = 1; repeat (6) cyc();
        check_eq("t4_no_alarm", 32'(seq_state), 32'd1);
        alarm_out_n = 0; repeat (DEB) cyc();
        alarm_out_n = 1; repeat (6) cyc();
        check_eq("t4_alarm", 32'(seq_state), 32'd3);
        check_eq("t4_fault", 32'(fault), 32'd1);
        check_eq("t4_stopped", 32'(motor_state), 32'd0);
        host_cmd(2'b11);
        cnt = 0;
        while (motor_alarm_reset == 1 && cnt < 200) begin cnt++; cyc(); end
        check_eq("t4_pulse_len", 32'(cnt), 32'(PULSE));
        leave_state(3'd4, "t4_clear_timeout");
        check_eq("t4_idle", 32'(seq_state), 32'd0);
        check_eq("t4_fault_clr", 32'(fault), 32'd0);

        // 5: retries up to lockout, then panel recovery
        host_cmd(2'b01);
        alarm_out_n = 0;
        reach_state(3'd3, "t5_alarm");
        for (int i = 0; i < MAXR; i++) begin
            reach_state(3'd3, "t5_back_in_alarm");
            panel_cmd(2'b11);
            leave_state(3'd4, "t5_clear_timeout");
            check_eq("t5_retry", 32'(retry_cnt), 32'(i + 1));
        end
        check_eq("t5_lockout", 32'(seq_state), 32'd5);
        host_cmd(2'b11);
        check_eq("t5_host_refused", 32'(rdy_h), 32'd0);
        panel_cmd(2'b11);
        check_eq("t5_panel_taken", 32'(rdy_p), 32'd1);
        check_eq("t5_still_locked", 32'(seq_state), 32'd5);
        alarm_out_n = 1; repeat (4) cyc();
        panel_cmd(2'b11);
        check_eq("t5_recovered", 32'(seq_state), 32'd0);
        check_eq("t5_retry_clr", 32'(retry_cnt), 32'd0);

        // 6: asynchronous reset in the middle of a clear pulse
        alarm_out_n = 0;
        reach_state(3'd3, "t6_alarm");
        host_cmd(2'b11);
        alarm_out_n = 1;
        repeat (3) cyc();
        check_eq("t6_pulse_on", 32'(motor_alarm_reset), 32'd1);
        #2 sys_rst_n = 0;
        #1;
        check_eq("t6_pulse_killed", 32'(motor_alarm_reset), 32'd0);
        check_eq("t6_state_rst", 32'(seq_state), 32'd0);
        model_reset();
        @(negedge sys_clk);
        repeat (2) cyc();
        sys_rst_n = 1;
        cyc();
        check_eq("t6_idle", 32'(seq_state), 32'd0);
        check_eq("t6_retry", 32'(retry_cnt), 32'd0);

        // random traffic with occasional alarm bursts
        burst = 0;
        for (int i = 0; i < 3000; i++) begin
            host_req_valid  = ($urandom_range(0, 2) == 0);
            host_req_cmd    = 2'($urandom_range(0, 3));
            panel_req_valid = ($urandom_range(0, 2) == 0);
            panel_req_cmd   = 2'($urandom_range(0, 3));
            if (burst > 0) begin
                alarm_out_n = 0; burst--;
            end else begin
                alarm_out_n = 1;
                if ($urandom_range(0, 99) == 0) burst = $urandom_range(1, 25);
            end
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
